// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchronise, debounce, and emit press/release
// pulses with optional auto-repeat while a button is held.

module btn_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);
    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);
    localparam int   DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int   RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   RW       = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HELD, REPEATING} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          db_cnt;
    logic [RW-1:0]          rcnt;
    state_t                 state;
    logic                   sample, differ, settle, rise, fall;

    // Synchronizer resets to the idle pin level so a held button reads as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= {SYNC_STAGES{IDLE_RAW}};
        else     sync <= {sync[SYNC_STAGES-2:0], raw};
    end

    assign sample = sync[SYNC_STAGES-1] ^ IDLE_RAW;
    assign differ = (sample != level);
    assign settle = differ && (db_cnt == DB_LAST);
    assign rise   = settle && !level;
    assign fall   = settle && level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (!differ) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= ~level;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Level fall is handled first so a release always beats a coincident repeat expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rcnt  <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            if (fall) begin
                state <= IDLE;
                rcnt  <= '0;
                rel   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= HELD;
                            rcnt  <= '0;
                            press <= 1'b1;
                        end
                    end
                    HELD: begin
                        if (REPEAT_EN != 0) begin
                            if (rcnt == DELAY_LAST) begin
                                press <= 1'b1;
                                state <= REPEATING;
                                rcnt  <= '0;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                    end
                    REPEATING: begin
                        if (rcnt == PERIOD_LAST) begin
                            press <= 1'b1;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             btn_any
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk  (Clk),
            .rst  (Reset),
            .raw  (btn_in[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i])
        );
    end

    assign btn_any = |btn_level;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at default parameters; edge k is the k-th rising
// edge after the stimulus change, outputs sampled 1 time unit after each edge.

module tb_button_conditioner;
    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] btn_in;
    logic [1:0] btn_level, btn_press, btn_release;
    logic       btn_any;

    int n_cmp  = 0;
    int n_fail = 0;

    button_conditioner dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_any    (btn_any)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] exp_lv, exp_pr, exp_rl;
        Reset  = 1'b1;
        btn_in = 2'b10;
        tick();
        tick();
        n_cmp++; if (btn_level !== 2'b00)   begin n_fail++; $display("FAIL reset_level got=%b exp=00", btn_level); end
        n_cmp++; if (btn_press !== 2'b00)   begin n_fail++; $display("FAIL reset_press got=%b exp=00", btn_press); end
        n_cmp++; if (btn_release !== 2'b00) begin n_fail++; $display("FAIL reset_release got=%b exp=00", btn_release); end
        n_cmp++; if (btn_any !== 1'b0)      begin n_fail++; $display("FAIL reset_any got=%b exp=0", btn_any); end
        Reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lv = (k >= 6) ? 2'b01 : 2'b00;
            exp_pr = (k == 6) ? 2'b01 : 2'b00;
            n_cmp++; if (btn_level !== exp_lv) begin n_fail++; $display("FAIL post_reset_level edge=%0d got=%b exp=%b", k, btn_level, exp_lv); end
            n_cmp++; if (btn_press !== exp_pr) begin n_fail++; $display("FAIL post_reset_press edge=%0d got=%b exp=%b", k, btn_press, exp_pr); end
        end
        btn_in = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lv = (k < 6) ? 2'b01 : 2'b00;
            exp_rl = (k == 6) ? 2'b01 : 2'b00;
            n_cmp++; if (btn_level !== exp_lv)   begin n_fail++; $display("FAIL unpress_level edge=%0d got=%b exp=%b", k, btn_level, exp_lv); end
            n_cmp++; if (btn_release !== exp_rl) begin n_fail++; $display("FAIL unpress_release edge=%0d got=%b exp=%b", k, btn_release, exp_rl); end
            n_cmp++; if (btn_press !== 2'b00)    begin n_fail++; $display("FAIL unpress_press edge=%0d got=%b exp=00", k, btn_press); end
        end
    endtask

    task automatic test_press();
        logic [1:0] exp_lv, exp_pr;
        btn_in = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lv = (k >= 6) ? 2'b01 : 2'b00;
            exp_pr = (k == 6) ? 2'b01 : 2'b00;
            n_cmp++; if (btn_level !== exp_lv)   begin n_fail++; $display("FAIL press_level edge=%0d got=%b exp=%b", k, btn_level, exp_lv); end
            n_cmp++; if (btn_press !== exp_pr)   begin n_fail++; $display("FAIL press_pulse edge=%0d got=%b exp=%b", k, btn_press, exp_pr); end
            n_cmp++; if (btn_any !== (k >= 6))   begin n_fail++; $display("FAIL press_any edge=%0d got=%b exp=%b", k, btn_any, (k >= 6)); end
        end
        btn_in = 2'b11;
        for (int k = 1; k <= 8; k++) tick();
        n_cmp++; if (btn_any !== 1'b0) begin n_fail++; $display("FAIL press_idle_any got=%b exp=0", btn_any); end
    endtask

    task automatic test_glitch();
        // ch1 raw: low 3, high 1, low 3, then high
        for (int k = 0; k < 14; k++) begin
            btn_in = (k < 3 || (k >= 4 && k < 7)) ? 2'b01 : 2'b11;
            tick();
            n_cmp++;
            if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0 || btn_release[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch step=%0d level=%b press=%b release=%b exp=000", k, btn_level[1], btn_press[1], btn_release[1]);
            end
        end
    endtask

    task automatic test_repeat();
        logic exp_pr, exp_rl;
        btn_in = 2'b10;
        for (int k = 1; k <= 38; k++) begin
            tick();
            exp_pr = (k == 6) || (k >= 16 && (k - 16) % 5 == 0);
            n_cmp++; if (btn_press[0] !== exp_pr) begin n_fail++; $display("FAIL repeat_press edge=%0d got=%b exp=%b", k, btn_press[0], exp_pr); end
        end
        btn_in = 2'b11;
        for (int k = 39; k <= 54; k++) begin
            tick();
            exp_pr = (k == 41);
            exp_rl = (k == 44);
            n_cmp++; if (btn_press[0] !== exp_pr)   begin n_fail++; $display("FAIL repeat_tail_press edge=%0d got=%b exp=%b", k, btn_press[0], exp_pr); end
            n_cmp++; if (btn_release[0] !== exp_rl) begin n_fail++; $display("FAIL repeat_release edge=%0d got=%b exp=%b", k, btn_release[0], exp_rl); end
        end
    endtask

    task automatic test_release_collision();
        btn_in = 2'b10;
        for (int k = 1; k <= 40; k++) tick();
        btn_in = 2'b11;
        for (int k = 41; k <= 45; k++) tick();
        tick(); // edge 46: level fall and repeat expiry coincide
        n_cmp++; if (btn_release[0] !== 1'b1) begin n_fail++; $display("FAIL collide_release got=%b exp=1", btn_release[0]); end
        n_cmp++; if (btn_press[0] !== 1'b0)   begin n_fail++; $display("FAIL collide_press got=%b exp=0", btn_press[0]); end
        n_cmp++; if (btn_level[0] !== 1'b0)   begin n_fail++; $display("FAIL collide_level got=%b exp=0", btn_level[0]); end
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++; if (btn_press[0] !== 1'b0 || btn_release[0] !== 1'b0) begin n_fail++; $display("FAIL collide_after step=%0d press=%b release=%b exp=00", k, btn_press[0], btn_release[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_pr;
        btn_in = 2'b00;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_pr = (k == 6 || k == 16) ? 2'b11 : 2'b00;
            n_cmp++; if (btn_press !== exp_pr) begin n_fail++; $display("FAIL both_press edge=%0d got=%b exp=%b", k, btn_press, exp_pr); end
        end
        n_cmp++; if (btn_level !== 2'b11) begin n_fail++; $display("FAIL both_level got=%b exp=11", btn_level); end
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (btn_level !== 2'b00 || btn_any !== 1'b0) begin n_fail++; $display("FAIL async_reset level=%b any=%b exp=00/0", btn_level, btn_any); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (btn_press !== 2'b00 || btn_release !== 2'b00) begin n_fail++; $display("FAIL in_reset step=%0d press=%b release=%b exp=00/00", k, btn_press, btn_release); end
        end
        btn_in = 2'b11;
        Reset  = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (btn_level !== 2'b00 || btn_press !== 2'b00 || btn_release !== 2'b00) begin
                n_fail++;
                $display("FAIL post_reset_quiet edge=%0d level=%b press=%b release=%b exp=00", k, btn_level, btn_press, btn_release);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        test_release_collision();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
